// File: rtl/button_pulse_gen_if.sv
// Button pin and debounced outputs of button_pulse_gen, grouped as one bundle.
// master: the board/bench side that drives the pin; slave: the pulse generator.
interface button_pulse_gen_if;
   logic btn_raw;
   logic impulse;
   logic btn_level;

   modport master (
      output btn_raw,
      input  impulse,
      input  btn_level
   );

   modport slave (
      input  btn_raw,
      output impulse,
      output btn_level
   );
endinterface

// File: rtl/button_pulse_gen.sv
// Synchronises and debounces a raw push-button into a one-cycle impulse per press
// plus a debounced level. Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module button_pulse_gen #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input logic                clk,
   input logic                nrst,
   button_pulse_gen_if.slave  bus
);

   localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CntMax = (DEBOUNCE_CYCLES > RptMax) ? DEBOUNCE_CYCLES : RptMax;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StPressed,
      StReleaseWait
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   impulse_q, impulse_d;
   logic                   btn_level_q, btn_level_d;
   logic                   btn_s;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
   localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);

   logic [CntW-1:0] rpt_q, rpt_d;
   // Low until the first repeat pulse; selects REPEAT_DELAY vs REPEAT_PERIOD spacing.
   logic            rpt_arm_q, rpt_arm_d;
`endif

   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
   assign btn_s  = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      impulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      // Repeat state only survives a cycle spent in PRESSED with the button still down.
      rpt_d     = '0;
      rpt_arm_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!btn_s) begin
               state_d = StIdle;
            end else if (cnt_q == DebLast) begin
               state_d   = StPressed;
               impulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StPressed: begin
            if (!btn_s) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end else begin
`ifdef BTN_AUTOREPEAT_EN
               rpt_arm_d = rpt_arm_q;
               if (rpt_arm_q ? (rpt_q == PeriodLast) : (rpt_q == DelayLast)) begin
                  impulse_d = 1'b1;
                  rpt_d     = '0;
                  rpt_arm_d = 1'b1;
               end else begin
                  rpt_d = rpt_q + CntW'(1);
               end
`endif
            end
         end
         StReleaseWait: begin
            if (btn_s) begin
               state_d = StPressed;
            end else if (cnt_q == DebLast) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      btn_level_d = (state_d == StPressed) || (state_d == StReleaseWait);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q      <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
         state_q     <= StIdle;
         cnt_q       <= '0;
         impulse_q   <= 1'b0;
         btn_level_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q       <= '0;
         rpt_arm_q   <= 1'b0;
`endif
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         impulse_q   <= impulse_d;
         btn_level_q <= btn_level_d;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q       <= rpt_d;
         rpt_arm_q   <= rpt_arm_d;
`endif
      end
   end

   assign bus.impulse   = impulse_q;
   assign bus.btn_level = btn_level_q;

endmodule
